// File: rtl/lc3_control.sv
// lc3_control: hardwired LC-3 microsequencer using the Patt & Patel state numbers.
// This is a Moore FSM. Every datapath control is decoded from the current state
// alone. The one exception is reset: while rst is low, all loads, gates and
// memory strobes are held at 0 and all mux selects read 0.
// Optional feature: define LC3_TRAP_EN to build the TRAP sequence (states 15, 28, 30).
// Without it, TRAP executes as a one-cycle NOP.
// Memory handshake: a memory state (33, 24, 25, 29, 16, 28) keeps mio_en high
// and holds until mem_ready is 1. The access completes on that cycle and the FSM
// moves on at the next edge, so each memory state lasts at least one cycle.
module lc3_control #(
  parameter logic [5:0] RESET_STATE = 6'd18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        ben,
  input  logic        mem_ready,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_ben,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        ld_pc,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  pcmux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic        marmux,
  output logic [1:0]  drmux,
  output logic [1:0]  sr1mux,
  output logic [1:0]  aluk,
  output logic        mio_en,
  output logic        r_w,
  output logic [5:0]  state
);

  typedef enum logic [5:0] {
    S_BR       = 6'd0,
    S_ADD      = 6'd1,
    S_LD       = 6'd2,
    S_ST       = 6'd3,
    S_JSR      = 6'd4,
    S_AND      = 6'd5,
    S_LDR      = 6'd6,
    S_STR      = 6'd7,
    S_RTI      = 6'd8,
    S_NOT      = 6'd9,
    S_LDI      = 6'd10,
    S_STI      = 6'd11,
    S_JMP      = 6'd12,
    S_RSV      = 6'd13,
    S_LEA      = 6'd14,
    S_TRAP     = 6'd15,
    S_ST_WR    = 6'd16,
    S_FETCH    = 6'd18,
    S_JSRR     = 6'd20,
    S_JSR_OFF  = 6'd21,
    S_BR_TAKE  = 6'd22,
    S_ST_MDR   = 6'd23,
    S_LDI_RD   = 6'd24,
    S_LD_RD    = 6'd25,
    S_LDI_MAR  = 6'd26,
    S_LD_DR    = 6'd27,
    S_TRAP_RD  = 6'd28,
    S_STI_RD   = 6'd29,
    S_TRAP_PC  = 6'd30,
    S_STI_MAR  = 6'd31,
    S_DECODE   = 6'd32,
    S_FETCH_RD = 6'd33,
    S_IR_LD    = 6'd35
  } state_t;

  state_t state_q;
  state_t state_d;

  // Only the opcode and ir[11] (the JSR/JSRR selector) steer the sequencer.
  logic unused_ir;
  assign unused_ir = ^ir[10:0];

  assign state = state_q;

  // State register. Asserting reset puts the FSM back at the start of fetch at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= state_t'(RESET_STATE);
    else      state_q <= state_d;
  end

  // Next-state and per-state control decode. Reset forcing is applied last.
  always_comb begin
    state_d     = S_FETCH;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_ben      = 1'b0;
    ld_reg      = 1'b0;
    ld_cc       = 1'b0;
    ld_pc       = 1'b0;
    gate_pc     = 1'b0;
    gate_mdr    = 1'b0;
    gate_alu    = 1'b0;
    gate_marmux = 1'b0;
    pcmux       = 2'd0;
    addr1mux    = 1'b0;
    addr2mux    = 2'd0;
    marmux      = 1'b0;
    drmux       = 2'd0;
    sr1mux      = 2'd0;
    aluk        = 2'd0;
    mio_en      = 1'b0;
    r_w         = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        gate_pc = 1'b1; ld_mar = 1'b1; ld_pc = 1'b1; pcmux = 2'd0;
        state_d = S_FETCH_RD;
      end
      S_FETCH_RD: begin
        mio_en = 1'b1; ld_mdr = 1'b1;
        state_d = mem_ready ? S_IR_LD : S_FETCH_RD;
      end
      S_IR_LD: begin
        gate_mdr = 1'b1; ld_ir = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ld_ben  = 1'b1;
        state_d = state_t'({2'b00, ir[15:12]});
      end
      S_ADD, S_AND, S_NOT: begin
        gate_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; sr1mux = 2'd1;
        aluk = (state_q == S_ADD) ? 2'd0 : (state_q == S_AND) ? 2'd1 : 2'd2;
        state_d = S_FETCH;
      end
      S_BR: begin
        state_d = ben ? S_BR_TAKE : S_FETCH;
      end
      S_BR_TAKE: begin
        ld_pc = 1'b1; pcmux = 2'd2; addr1mux = 1'b0; addr2mux = 2'd2;
        state_d = S_FETCH;
      end
      S_JMP, S_JSRR: begin
        ld_pc = 1'b1; pcmux = 2'd2; addr1mux = 1'b1; addr2mux = 2'd0; sr1mux = 2'd1;
        state_d = S_FETCH;
      end
      S_JSR: begin
        gate_pc = 1'b1; ld_reg = 1'b1; drmux = 2'd1;
        state_d = ir[11] ? S_JSR_OFF : S_JSRR;
      end
      S_JSR_OFF: begin
        ld_pc = 1'b1; pcmux = 2'd2; addr1mux = 1'b0; addr2mux = 2'd3;
        state_d = S_FETCH;
      end
      // PC-relative address calculations: PC + SEXT(off9).
      S_LD, S_ST, S_LDI, S_STI: begin
        gate_marmux = 1'b1; marmux = 1'b1; ld_mar = 1'b1;
        addr1mux = 1'b0; addr2mux = 2'd2;
        state_d = (state_q == S_LD)  ? S_LD_RD  :
                  (state_q == S_ST)  ? S_ST_MDR :
                  (state_q == S_LDI) ? S_LDI_RD : S_STI_RD;
      end
      // Base-relative address calculations: BaseR + SEXT(off6).
      S_LDR, S_STR: begin
        gate_marmux = 1'b1; marmux = 1'b1; ld_mar = 1'b1;
        addr1mux = 1'b1; addr2mux = 2'd1; sr1mux = 2'd1;
        state_d = (state_q == S_LDR) ? S_LD_RD : S_ST_MDR;
      end
      // LEA writes the effective address to DR and leaves the condition codes alone.
      S_LEA: begin
        gate_marmux = 1'b1; marmux = 1'b1; ld_reg = 1'b1;
        addr1mux = 1'b0; addr2mux = 2'd2;
        state_d = S_FETCH;
      end
      S_LDI_RD: begin
        mio_en = 1'b1; ld_mdr = 1'b1;
        state_d = mem_ready ? S_LDI_MAR : S_LDI_RD;
      end
      S_LDI_MAR: begin
        gate_mdr = 1'b1; ld_mar = 1'b1;
        state_d = S_LD_RD;
      end
      S_LD_RD: begin
        mio_en = 1'b1; ld_mdr = 1'b1;
        state_d = mem_ready ? S_LD_DR : S_LD_RD;
      end
      S_LD_DR: begin
        gate_mdr = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1;
        state_d = S_FETCH;
      end
      S_STI_RD: begin
        mio_en = 1'b1; ld_mdr = 1'b1;
        state_d = mem_ready ? S_STI_MAR : S_STI_RD;
      end
      S_STI_MAR: begin
        gate_mdr = 1'b1; ld_mar = 1'b1;
        state_d = S_ST_MDR;
      end
      S_ST_MDR: begin
        gate_alu = 1'b1; aluk = 2'd3; sr1mux = 2'd0; ld_mdr = 1'b1;
        state_d = S_ST_WR;
      end
      S_ST_WR: begin
        mio_en = 1'b1; r_w = 1'b1;
        state_d = mem_ready ? S_FETCH : S_ST_WR;
      end
`ifdef LC3_TRAP_EN
      S_TRAP: begin
        gate_marmux = 1'b1; marmux = 1'b0; ld_mar = 1'b1;
        state_d = S_TRAP_RD;
      end
      S_TRAP_RD: begin
        mio_en = 1'b1; ld_mdr = 1'b1; gate_pc = 1'b1; ld_reg = 1'b1; drmux = 2'd1;
        state_d = mem_ready ? S_TRAP_PC : S_TRAP_RD;
      end
      S_TRAP_PC: begin
        gate_mdr = 1'b1; ld_pc = 1'b1; pcmux = 2'd1;
        state_d = S_FETCH;
      end
`endif
      // RTI, the reserved opcode, TRAP when disabled, and unused encodings: NOP back to fetch.
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (!rst) begin
      ld_mar = 1'b0; ld_mdr = 1'b0; ld_ir = 1'b0; ld_ben = 1'b0;
      ld_reg = 1'b0; ld_cc = 1'b0; ld_pc = 1'b0;
      gate_pc = 1'b0; gate_mdr = 1'b0; gate_alu = 1'b0; gate_marmux = 1'b0;
      pcmux = 2'd0; addr1mux = 1'b0; addr2mux = 2'd0; marmux = 1'b0;
      drmux = 2'd0; sr1mux = 2'd0; aluk = 2'd0;
      mio_en = 1'b0; r_w = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_control.sv
// tb_lc3_control: testbench for lc3_control. Each instruction's expected state
// path comes from a table keyed by opcode. The expected controls in each state
// come from sets of states built from the micro-op descriptions.
module tb_lc3_control;

`ifdef LC3_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        ben;
  logic        mem_ready;
  logic        ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
  logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0]  pcmux;
  logic        addr1mux;
  logic [1:0]  addr2mux;
  logic        marmux;
  logic [1:0]  drmux, sr1mux, aluk;
  logic        mio_en, r_w;
  logic [5:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] path_q[$];

  lc3_control dut (
    .clk(clk), .rst(rst), .ir(ir), .ben(ben), .mem_ready(mem_ready),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_ben(ld_ben),
    .ld_reg(ld_reg), .ld_cc(ld_cc), .ld_pc(ld_pc),
    .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_alu(gate_alu),
    .gate_marmux(gate_marmux), .pcmux(pcmux), .addr1mux(addr1mux),
    .addr2mux(addr2mux), .marmux(marmux), .drmux(drmux), .sr1mux(sr1mux),
    .aluk(aluk), .mio_en(mio_en), .r_w(r_w), .state(state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] got_ctl();
    return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
            gate_pc, gate_mdr, gate_alu, gate_marmux, mio_en, r_w};
  endfunction

  function automatic bit is_mem(input logic [5:0] s);
    return (s inside {6'd33, 6'd24, 6'd25, 6'd29, 6'd16}) || (TRAP_EN && s == 6'd28);
  endfunction

  // Expected load, gate and memory strobes, one bit per signal, set from which states use it.
  function automatic logic [12:0] exp_ctl(input logic [5:0] s);
    logic [12:0] e;
    e[12] = (s inside {6'd18, 6'd2, 6'd6, 6'd10, 6'd3, 6'd7, 6'd11, 6'd26, 6'd31}) || (TRAP_EN && s == 6'd15);
    e[11] = (s inside {6'd33, 6'd24, 6'd25, 6'd29, 6'd23}) || (TRAP_EN && s == 6'd28);
    e[10] = (s == 6'd35);
    e[9]  = (s == 6'd32);
    e[8]  = (s inside {6'd1, 6'd5, 6'd9, 6'd4, 6'd14, 6'd27}) || (TRAP_EN && s == 6'd28);
    e[7]  = (s inside {6'd1, 6'd5, 6'd9, 6'd27});
    e[6]  = (s inside {6'd18, 6'd22, 6'd12, 6'd21, 6'd20}) || (TRAP_EN && s == 6'd30);
    e[5]  = (s inside {6'd18, 6'd4}) || (TRAP_EN && s == 6'd28);
    e[4]  = (s inside {6'd35, 6'd26, 6'd27, 6'd31}) || (TRAP_EN && s == 6'd30);
    e[3]  = (s inside {6'd1, 6'd5, 6'd9, 6'd23});
    e[2]  = (s inside {6'd2, 6'd6, 6'd14, 6'd10, 6'd3, 6'd7, 6'd11}) || (TRAP_EN && s == 6'd15);
    e[1]  = is_mem(s);
    e[0]  = (s == 6'd16);
    return e;
  endfunction

  task automatic check_outputs(input logic [5:0] s);
    logic [12:0] e;
    e = exp_ctl(s);
    check($sformatf("ctl@%0d", s), 16'(got_ctl()), 16'(e));
    check($sformatf("one_gate@%0d", s), 16'(int'(gate_pc) + int'(gate_mdr) + int'(gate_alu) + int'(gate_marmux) <= 1), 16'd1);
    if (e[6]) check($sformatf("pcmux@%0d", s), 16'(pcmux), (s == 6'd18) ? 16'd0 : (s == 6'd30) ? 16'd1 : 16'd2);
    if (e[8]) check($sformatf("drmux@%0d", s), 16'(drmux), (s inside {6'd4, 6'd28}) ? 16'd1 : 16'd0);
    if (s inside {6'd1, 6'd5, 6'd9, 6'd23})
      check($sformatf("aluk@%0d", s), 16'(aluk), (s == 6'd1) ? 16'd0 : (s == 6'd5) ? 16'd1 : (s == 6'd9) ? 16'd2 : 16'd3);
    if (s inside {6'd1, 6'd5, 6'd9, 6'd12, 6'd20, 6'd23})
      check($sformatf("sr1mux@%0d", s), 16'(sr1mux), (s == 6'd23) ? 16'd0 : 16'd1);
    if (s inside {6'd12, 6'd20, 6'd21, 6'd22}) begin
      check($sformatf("addr1mux@%0d", s), 16'(addr1mux), (s inside {6'd12, 6'd20}) ? 16'd1 : 16'd0);
      check($sformatf("addr2mux@%0d", s), 16'(addr2mux), (s == 6'd22) ? 16'd2 : (s == 6'd21) ? 16'd3 : 16'd0);
    end
    if (e[2]) check($sformatf("marmux@%0d", s), 16'(marmux), (s == 6'd15) ? 16'd0 : 16'd1);
  endtask

  // Expected state path for one instruction, fetch included.
  task automatic build_path(input logic [15:0] instr, input logic b);
    logic [5:0] op;
    op = {2'b00, instr[15:12]};
    path_q = '{6'd18, 6'd33, 6'd35, 6'd32, op};
    case (op)
      6'd0:       if (b) path_q.push_back(6'd22);
      6'd4:       path_q.push_back(instr[11] ? 6'd21 : 6'd20);
      6'd2, 6'd6: begin path_q.push_back(6'd25); path_q.push_back(6'd27); end
      6'd10:      path_q = {path_q, 6'd24, 6'd26, 6'd25, 6'd27};
      6'd3, 6'd7: begin path_q.push_back(6'd23); path_q.push_back(6'd16); end
      6'd11:      path_q = {path_q, 6'd29, 6'd31, 6'd23, 6'd16};
      6'd15:      if (TRAP_EN) begin path_q.push_back(6'd28); path_q.push_back(6'd30); end
      default:    ;
    endcase
  endtask

  // One expected state. A memory state gets `stalls` cycles with mem_ready low, then one with it high.
  task automatic do_state(input logic [5:0] es, input int stalls);
    for (int c = 0; c <= stalls; c++) begin
      mem_ready = is_mem(es) ? (c == stalls) : 1'($urandom_range(1, 0));
      @(negedge clk);
      check("state", 16'(state), 16'(es));
      check_outputs(es);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic b, input int max_stall,
                           input int sp_state, input int sp_n);
    logic [5:0] s;
    int n;
    ir  = instr;
    ben = b;
    build_path(instr, b);
    while (path_q.size() > 0) begin
      s = path_q.pop_front();
      n = 0;
      if (is_mem(s)) n = (int'(s) == sp_state) ? sp_n : $urandom_range(max_stall, 0);
      do_state(s, n);
    end
  endtask

  initial begin
    rst = 1'b0; ir = 16'h0000; ben = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 16'(state), 16'd18);
    check("rst_ctl", 16'(got_ctl()), 16'd0);
    check("rst_mux", 16'({pcmux, addr1mux, addr2mux, marmux, drmux, sr1mux, aluk}), 16'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    run_instr(16'h1261, 1'b0, 0, -1, 0);   // ADD
    run_instr(16'h5262, 1'b0, 1, -1, 0);   // AND
    run_instr(16'h927F, 1'b0, 1, -1, 0);   // NOT
    run_instr(16'h0A05, 1'b1, 0, -1, 0);   // BRnp taken
    run_instr(16'h0A05, 1'b0, 0, -1, 0);   // BRnp not taken
    run_instr(16'hA002, 1'b0, 0, 24, 3);   // LDI, three stall cycles in 24
    run_instr(16'hB002, 1'b0, 0, -1, 0);   // STI
    run_instr(16'hF025, 1'b0, 1, -1, 0);   // TRAP
    run_instr(16'h4801, 1'b0, 0, -1, 0);   // JSR
    run_instr(16'h4080, 1'b0, 0, -1, 0);   // JSRR
    run_instr(16'hC1C0, 1'b0, 0, -1, 0);   // JMP
    run_instr(16'hE005, 1'b0, 0, -1, 0);   // LEA
    run_instr(16'h8000, 1'b0, 0, -1, 0);   // RTI as NOP
    run_instr(16'hD000, 1'b0, 0, -1, 0);   // reserved

    // Reset in the middle of the state-25 read of an LDI.
    ir = 16'hA002; ben = 1'b0;
    do_state(6'd18, 0); do_state(6'd33, 0); do_state(6'd35, 0); do_state(6'd32, 0);
    do_state(6'd10, 0); do_state(6'd24, 1); do_state(6'd26, 0);
    mem_ready = 1'b0;
    #2;
    check("mid_state", 16'(state), 16'd25);
    check("mid_mio", 16'(mio_en), 16'd1);
    rst = 1'b0;
    #1;
    check("arst_state", 16'(state), 16'd18);
    check("arst_mio", 16'(mio_en), 16'd0);
    check("arst_ctl", 16'(got_ctl()), 16'd0);
    @(posedge clk);
    #1;
    check("arst_hold", 16'(state), 16'd18);
    rst = 1'b1;
    run_instr(16'h1261, 1'b0, 1, -1, 0);

    // Random instructions, branch enables and memory stalls.
    for (int i = 0; i < 60; i++)
      run_instr(16'($urandom), 1'($urandom_range(1, 0)), 2, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
